// File: rtl/xor_parity_accum.sv
// Framed column-wise XOR accumulator with a held result handshake.
// Define XOR_PARITY_CHECK_EN to add the exp_parity comparison and out_err flag.
module xor_parity_accum #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_parity,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
`ifdef XOR_PARITY_CHECK_EN
    ,
    input  logic [WIDTH-1:0] exp_parity,
    output logic             out_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_parity_q, out_parity_d;
    logic             out_bit_q, out_bit_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;
`ifdef XOR_PARITY_CHECK_EN
    logic             out_err_q, out_err_d;
`endif

    logic             accept;
    logic [WIDTH-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             close_last;
    logic             close_max;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        // The first word of a frame seeds the accumulator instead of folding into it.
        acc_sum    = (state_q == IDLE) ? in_data : (acc_q ^ in_data);
        cnt_inc    = (state_q == IDLE) ? CNT_W'(1) : (cnt_q + CNT_W'(1));
        close_last = accept && in_last;
        close_max  = accept && !in_last && (state_q == ACCUM) && (cnt_inc == MAX_CNT);

        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_bit_d    = out_bit_q;
        out_count_d  = out_count_q;
        out_ovf_d    = out_ovf_q;
`ifdef XOR_PARITY_CHECK_EN
        out_err_d    = out_err_q;
`endif

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (close_last || close_max) begin
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                        out_parity_d = acc_sum;
                        out_bit_d    = ^acc_sum;
                        out_count_d  = cnt_inc;
                        out_ovf_d    = close_max;
`ifdef XOR_PARITY_CHECK_EN
                        out_err_d    = (acc_sum != exp_parity);
`endif
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready depends only on the next state, so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_parity_q <= '0;
            out_bit_q    <= 1'b0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
`ifdef XOR_PARITY_CHECK_EN
            out_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_bit_q    <= out_bit_d;
            out_count_q  <= out_count_d;
            out_ovf_q    <= out_ovf_d;
`ifdef XOR_PARITY_CHECK_EN
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_bit    = out_bit_q;
    assign out_count  = out_count_q;
    assign out_ovf    = out_ovf_q;
`ifdef XOR_PARITY_CHECK_EN
    assign out_err    = out_err_q;
`endif

endmodule

// File: tb/tb_xor_parity_accum.sv
// Directed bench for xor_parity_accum: frame table plus hand-written handshake,
// backpressure and reset sequences (check-port sequence when XOR_PARITY_CHECK_EN is set).
module tb_xor_parity_accum;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_parity;
    logic             out_bit;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
`ifdef XOR_PARITY_CHECK_EN
    logic [WIDTH-1:0] exp_parity;
    logic             out_err;
`endif

    int checks   = 0;
    int failures = 0;

    xor_parity_accum #(
        .WIDTH(WIDTH),
        .MAX_WORDS(MAX_WORDS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_parity(out_parity),
        .out_bit(out_bit),
        .out_count(out_count),
        .out_ovf(out_ovf)
`ifdef XOR_PARITY_CHECK_EN
        ,
        .exp_parity(exp_parity),
        .out_err(out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [15:0][7:0] words;
        logic [4:0]       n;
        logic             last;
        logic [7:0]       par;
        logic             pbit;
        logic [4:0]       cnt;
        logic             ovf;
    } vec_t;

    vec_t vec [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one word, clock it in, sample 1 time unit after the edge.
    task automatic send_word(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] par, input logic pbit,
                                input logic [4:0] cnt, input logic ovf);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, ".out_parity"}, {24'd0, out_parity}, {24'd0, par});
        chk({tag, ".out_bit"}, {31'd0, out_bit}, {31'd0, pbit});
        chk({tag, ".out_count"}, {27'd0, out_count}, {27'd0, cnt});
        chk({tag, ".out_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".rel_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".rel_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_frame(input int k);
        for (int i = 0; i < int'(vec[k].n); i++) begin
            send_word(vec[k].words[i], vec[k].last && (i == int'(vec[k].n) - 1));
            if (i < int'(vec[k].n) - 1)
                chk($sformatf("vec%0d.mid_valid", k), {31'd0, out_valid}, 32'd0);
        end
        check_result($sformatf("vec%0d", k), vec[k].par, vec[k].pbit, vec[k].cnt, vec[k].ovf);
        $display("frame vec%0d n=%0d parity=%02h bit=%0b count=%0d ovf=%0b",
                 k, vec[k].n, out_parity, out_bit, out_count, out_ovf);
        release_result($sformatf("vec%0d", k));
    endtask

    initial begin
        vec[0] = '0; vec[0].words[0] = 8'hA5; vec[0].words[1] = 8'h0F;
        vec[0].n = 5'd2; vec[0].last = 1'b1; vec[0].par = 8'hAA; vec[0].pbit = 1'b0; vec[0].cnt = 5'd2; vec[0].ovf = 1'b0;
        vec[1] = '0; vec[1].words[0] = 8'h01;
        vec[1].n = 5'd1; vec[1].last = 1'b1; vec[1].par = 8'h01; vec[1].pbit = 1'b1; vec[1].cnt = 5'd1; vec[1].ovf = 1'b0;
        vec[2] = '0; vec[2].words = {16{8'hFF}};
        vec[2].n = 5'd16; vec[2].last = 1'b0; vec[2].par = 8'h00; vec[2].pbit = 1'b0; vec[2].cnt = 5'd16; vec[2].ovf = 1'b1;
        vec[3] = '0; vec[3].words = {16{8'hFF}};
        vec[3].n = 5'd16; vec[3].last = 1'b1; vec[3].par = 8'h00; vec[3].pbit = 1'b0; vec[3].cnt = 5'd16; vec[3].ovf = 1'b0;
        vec[4] = '0; vec[4].words[0] = 8'h12; vec[4].words[1] = 8'h34;
        vec[4].n = 5'd2; vec[4].last = 1'b1; vec[4].par = 8'h26; vec[4].pbit = 1'b1; vec[4].cnt = 5'd2; vec[4].ovf = 1'b0;
        vec[5] = '0; vec[5].words[0] = 8'h80; vec[5].words[1] = 8'h40; vec[5].words[2] = 8'h20; vec[5].words[3] = 8'h01;
        vec[5].n = 5'd4; vec[5].last = 1'b1; vec[5].par = 8'hE1; vec[5].pbit = 1'b0; vec[5].cnt = 5'd4; vec[5].ovf = 1'b0;
        vec[6] = '0; vec[6].words[0] = 8'h01; vec[6].words[1] = 8'h02; vec[6].words[2] = 8'h04;
        vec[6].n = 5'd3; vec[6].last = 1'b1; vec[6].par = 8'h07; vec[6].pbit = 1'b1; vec[6].cnt = 5'd3; vec[6].ovf = 1'b0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
`ifdef XOR_PARITY_CHECK_EN
        exp_parity = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_parity", {24'd0, out_parity}, 32'd0);
        chk("rst.out_bit", {31'd0, out_bit}, 32'd0);
        chk("rst.out_count", {27'd0, out_count}, 32'd0);
        chk("rst.out_ovf", {31'd0, out_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sink always ready: result visible for exactly one cycle, then values are held.
        out_ready = 1'b1;
        send_word(8'hA5, 1'b0);
        send_word(8'h0F, 1'b1);
        chk("thru.out_valid", {31'd0, out_valid}, 32'd1);
        chk("thru.out_parity", {24'd0, out_parity}, 32'h0000_00AA);
        chk("thru.out_count", {27'd0, out_count}, 32'd2);
        @(posedge clk);
        #1;
        chk("thru.drop_valid", {31'd0, out_valid}, 32'd0);
        chk("thru.in_ready", {31'd0, in_ready}, 32'd1);
        chk("thru.held_parity", {24'd0, out_parity}, 32'h0000_00AA);
        $display("frame thru parity=%02h count=%0d", out_parity, out_count);
        out_ready = 1'b0;

        for (int k = 0; k < 7; k++) run_frame(k);

        // Backpressure: next frame word waits in DONE and is taken right after the handshake.
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_result($sformatf("bp%0d", c), 8'h33, 1'b0, 5'd2, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp.rel_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp.next", 8'h5A, 1'b0, 5'd1, 1'b0);
        $display("frame bp parity=%02h count=%0d", out_parity, out_count);
        release_result("bp.next");

        // Reset mid-frame after three words, then a clean single-word frame.
        send_word(8'h0F, 1'b0);
        send_word(8'h01, 1'b0);
        send_word(8'h10, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.out_parity", {24'd0, out_parity}, 32'd0);
        chk("mrst.out_count", {27'd0, out_count}, 32'd0);
        chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.idle_valid", {31'd0, out_valid}, 32'd0);
        send_word(8'h3C, 1'b1);
        check_result("mrst.next", 8'h3C, 1'b0, 5'd1, 1'b0);
        $display("frame mrst parity=%02h count=%0d", out_parity, out_count);
        release_result("mrst.next");

`ifdef XOR_PARITY_CHECK_EN
        exp_parity = 8'h26;
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b1);
        chk("err.match", {31'd0, out_err}, 32'd0);
        release_result("err.match");
        exp_parity = 8'h27;
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b1);
        chk("err.mismatch", {31'd0, out_err}, 32'd1);
        $display("frame err parity=%02h err=%0b", out_parity, out_err);
        release_result("err.mismatch");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
